// File: rtl/mul_int_u.sv
// mul_int_u -- unsigned radix-2 sequential shift-add multiplier, W x W -> 2W.
// Each operation takes W cycles. A start/busy/done handshake connects it to the
// datapath controller. The {hi,lo} product feeds the divider's dividend input.
// Optional feature macro: MUL_OVF_EN. When it is defined, the module adds the
// o_ovf port, which flags a product whose upper half is non-zero.
module mul_int_u #(
   parameter int W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [W-1:0]     i_mcand,
   input  logic [W-1:0]     i_mplier,
   output logic             o_busy,
   output logic             o_done,
   output logic [2*W-1:0]   o_prod
`ifdef MUL_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   // The counter is one bit wider than needed for W-1, so it can rest at W.
   localparam int CW = $clog2(W) + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state;
   logic [W-1:0]       r_m;       // latched multiplicand
   logic [2*W-1:0]     r_p;       // partial product {hi, lo}; lo starts as the multiplier
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [2*W-1:0]     r_prod;

   logic [W-1:0]       w_addend;
   logic [W:0]         w_sum;
   logic [2*W-1:0]     w_p_next;
   logic               w_last;

   // One iteration. Add M to the upper half when the LSB is set. The carry out
   // of that add is the W+1-th sum bit. It shifts into the MSB, so it never
   // needs its own register.
   assign w_addend = r_p[0] ? r_m : '0;
   assign w_sum    = {1'b0, r_p[2*W-1:W]} + {1'b0, w_addend};
   assign w_p_next = {w_sum, r_p[W-1:1]};
   assign w_last   = (r_cnt == CW'(W - 1));

   // Control FSM and datapath: accept start in IDLE, iterate W times in RUN,
   // then publish the product with a single-cycle done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_m     <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_prod  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_m     <= i_mcand;
                  r_p     <= {{W{1'b0}}, i_mplier};
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_p   <= w_p_next;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  r_prod  <= w_p_next;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MUL_OVF_EN
   logic r_ovf;

   // Overflow flag: the result does not fit in W bits. It is captured with the
   // product and holds with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == S_RUN && w_last) begin
         r_ovf <= |w_p_next[2*W-1:W];
      end
   end

   assign o_ovf = r_ovf;
`endif

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_prod = r_prod;

endmodule
